// File: rtl/instruction_decoder.sv
// RV32I + Zicsr + machine-mode system decoder: one-hot op groups plus raw
// register/immediate fields, all registered with a single cycle of latency.
module instruction_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction_code,
  input  logic        en,
  output logic        invalid_instruction,
  output logic [18:0] alu_op,
  output logic [8:0]  jmp_op,
  output logic [8:0]  mem_op,
  output logic        cust_op,
  output logic [5:0]  csr_op,
  output logic [7:0]  mechie_op,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  imm_2531,
  output logic [19:0] imm_1231,
  output logic [11:0] imm_2032
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instruction_code[6:0];
  assign funct3 = instruction_code[14:12];
  assign funct7 = instruction_code[31:25];

  logic        invalid_d, invalid_q;
  logic [18:0] alu_op_d, alu_op_q;
  logic [8:0]  jmp_op_d, jmp_op_q;
  logic [8:0]  mem_op_d, mem_op_q;
  logic        cust_op_d, cust_op_q;
  logic [5:0]  csr_op_d, csr_op_q;
  logic [7:0]  mechie_op_d, mechie_op_q;
  logic [4:0]  rd_d, rd_q, rs1_d, rs1_q, rs2_d, rs2_q;
  logic [6:0]  imm_2531_d, imm_2531_q;
  logic [19:0] imm_1231_d, imm_1231_q;
  logic [11:0] imm_2032_d, imm_2032_q;

  always_comb begin
    alu_op_d    = '0;
    jmp_op_d    = '0;
    mem_op_d    = '0;
    cust_op_d   = 1'b0;
    csr_op_d    = '0;
    mechie_op_d = '0;
    invalid_d   = 1'b0;

    // Fields are raw slices regardless of instruction format or enable.
    rd_d       = instruction_code[11:7];
    rs1_d      = instruction_code[19:15];
    rs2_d      = instruction_code[24:20];
    imm_2531_d = instruction_code[31:25];
    imm_1231_d = instruction_code[31:12];
    imm_2032_d = instruction_code[31:20];

    if (en) begin
      case (opcode)
        7'b0110011: begin
          if (funct7 == 7'b0000000) begin
            case (funct3)
              3'b000:  alu_op_d[0] = 1'b1;
              3'b001:  alu_op_d[2] = 1'b1;
              3'b010:  alu_op_d[3] = 1'b1;
              3'b011:  alu_op_d[4] = 1'b1;
              3'b100:  alu_op_d[5] = 1'b1;
              3'b101:  alu_op_d[6] = 1'b1;
              3'b110:  alu_op_d[8] = 1'b1;
              default: alu_op_d[9] = 1'b1;
            endcase
          end else if (funct7 == 7'b0100000) begin
            if (funct3 == 3'b000) alu_op_d[1] = 1'b1;
            else if (funct3 == 3'b101) alu_op_d[7] = 1'b1;
          end
        end
        7'b0010011: begin
          case (funct3)
            3'b000:  alu_op_d[10] = 1'b1;
            3'b010:  alu_op_d[11] = 1'b1;
            3'b011:  alu_op_d[12] = 1'b1;
            3'b100:  alu_op_d[13] = 1'b1;
            3'b110:  alu_op_d[14] = 1'b1;
            3'b111:  alu_op_d[15] = 1'b1;
            3'b001:  if (funct7 == 7'b0000000) alu_op_d[16] = 1'b1;
            default: begin
              if (funct7 == 7'b0000000) alu_op_d[17] = 1'b1;
              else if (funct7 == 7'b0100000) alu_op_d[18] = 1'b1;
            end
          endcase
        end
        7'b1101111: jmp_op_d[0] = 1'b1;
        7'b1100111: if (funct3 == 3'b000) jmp_op_d[1] = 1'b1;
        7'b1100011: begin
          case (funct3)
            3'b000:  jmp_op_d[2] = 1'b1;
            3'b001:  jmp_op_d[3] = 1'b1;
            3'b100:  jmp_op_d[4] = 1'b1;
            3'b101:  jmp_op_d[5] = 1'b1;
            3'b110:  jmp_op_d[6] = 1'b1;
            3'b111:  jmp_op_d[7] = 1'b1;
            default: ;
          endcase
        end
        7'b0010111: jmp_op_d[8] = 1'b1;
        7'b0000011: begin
          case (funct3)
            3'b000:  mem_op_d[0] = 1'b1;
            3'b001:  mem_op_d[1] = 1'b1;
            3'b010:  mem_op_d[2] = 1'b1;
            3'b100:  mem_op_d[3] = 1'b1;
            3'b101:  mem_op_d[4] = 1'b1;
            default: ;
          endcase
        end
        7'b0100011: begin
          case (funct3)
            3'b000:  mem_op_d[5] = 1'b1;
            3'b001:  mem_op_d[6] = 1'b1;
            3'b010:  mem_op_d[7] = 1'b1;
            default: ;
          endcase
        end
        7'b0110111: mem_op_d[8] = 1'b1;
        7'b1110011: begin
          // funct3=000 is the privileged space: only exact words are accepted.
          if (funct3 == 3'b000) begin
            case (instruction_code)
              32'h00000073: mechie_op_d[0] = 1'b1;
              32'h00100073: mechie_op_d[1] = 1'b1;
              32'h30200073: mechie_op_d[2] = 1'b1;
              32'h10200073: mechie_op_d[3] = 1'b1;
              32'h00200073: mechie_op_d[4] = 1'b1;
              32'h10500073: mechie_op_d[5] = 1'b1;
              default: ;
            endcase
          end else begin
            case (funct3)
              3'b001:  csr_op_d[0] = 1'b1;
              3'b010:  csr_op_d[1] = 1'b1;
              3'b011:  csr_op_d[2] = 1'b1;
              3'b101:  csr_op_d[3] = 1'b1;
              3'b110:  csr_op_d[4] = 1'b1;
              3'b111:  csr_op_d[5] = 1'b1;
              default: ;
            endcase
          end
        end
        7'b0001111: begin
          if (funct3 == 3'b000) mechie_op_d[6] = 1'b1;
          else if (funct3 == 3'b001) mechie_op_d[7] = 1'b1;
        end
        7'b1111111: cust_op_d = 1'b1;
        default: ;
      endcase

      invalid_d = ~(|{alu_op_d, jmp_op_d, mem_op_d, cust_op_d, csr_op_d, mechie_op_d});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      invalid_q   <= 1'b0;
      alu_op_q    <= '0;
      jmp_op_q    <= '0;
      mem_op_q    <= '0;
      cust_op_q   <= 1'b0;
      csr_op_q    <= '0;
      mechie_op_q <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_2531_q  <= '0;
      imm_1231_q  <= '0;
      imm_2032_q  <= '0;
    end else begin
      invalid_q   <= invalid_d;
      alu_op_q    <= alu_op_d;
      jmp_op_q    <= jmp_op_d;
      mem_op_q    <= mem_op_d;
      cust_op_q   <= cust_op_d;
      csr_op_q    <= csr_op_d;
      mechie_op_q <= mechie_op_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      imm_2531_q  <= imm_2531_d;
      imm_1231_q  <= imm_1231_d;
      imm_2032_q  <= imm_2032_d;
    end
  end

  assign invalid_instruction = invalid_q;
  assign alu_op              = alu_op_q;
  assign jmp_op              = jmp_op_q;
  assign mem_op              = mem_op_q;
  assign cust_op             = cust_op_q;
  assign csr_op              = csr_op_q;
  assign mechie_op           = mechie_op_q;
  assign rd                  = rd_q;
  assign rs1                 = rs1_q;
  assign rs2                 = rs2_q;
  assign imm_2531            = imm_2531_q;
  assign imm_1231            = imm_1231_q;
  assign imm_2032            = imm_2032_q;

endmodule

// File: tb/tb_instruction_decoder.sv
// Bench for instruction_decoder: directed vectors plus randomized words checked
// against a mask/match instruction table model.
module tb_instruction_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction_code;
  logic        en;
  logic        invalid_instruction;
  logic [18:0] alu_op;
  logic [8:0]  jmp_op;
  logic [8:0]  mem_op;
  logic        cust_op;
  logic [5:0]  csr_op;
  logic [7:0]  mechie_op;
  logic [4:0]  rd, rs1, rs2;
  logic [6:0]  imm_2531;
  logic [19:0] imm_1231;
  logic [11:0] imm_2032;

  instruction_decoder dut (
    .clk                 (clk),
    .rst                 (rst),
    .instruction_code    (instruction_code),
    .en                  (en),
    .invalid_instruction (invalid_instruction),
    .alu_op              (alu_op),
    .jmp_op              (jmp_op),
    .mem_op              (mem_op),
    .cust_op             (cust_op),
    .csr_op              (csr_op),
    .mechie_op           (mechie_op),
    .rd                  (rd),
    .rs1                 (rs1),
    .rs2                 (rs2),
    .imm_2531            (imm_2531),
    .imm_1231            (imm_1231),
    .imm_2032            (imm_2032)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instruction table: a word is instruction k when (word & mask) == match.
  // Group: 0 alu, 1 jmp, 2 mem, 3 csr, 4 mechie, 5 custom.
  logic [31:0] t_mask[$];
  logic [31:0] t_match[$];
  int          t_grp[$];
  int          t_bit[$];

  logic [6:0] opcs[11] = '{7'h33, 7'h13, 7'h6F, 7'h67, 7'h63, 7'h17,
                           7'h03, 7'h23, 7'h37, 7'h73, 7'h0F};

  wire [52:0] obs_ops  = {invalid_instruction, alu_op, jmp_op, mem_op, cust_op, csr_op, mechie_op};
  wire [53:0] obs_flds = {rd, rs1, rs2, imm_2531, imm_1231, imm_2032};

  task automatic add(input logic [31:0] mask, input logic [31:0] match, input int grp, input int b);
    t_mask.push_back(mask);
    t_match.push_back(match);
    t_grp.push_back(grp);
    t_bit.push_back(b);
  endtask

  task automatic init_table();
    add(32'hFE00707F, 32'h00000033, 0, 0);  add(32'hFE00707F, 32'h40000033, 0, 1);
    add(32'hFE00707F, 32'h00001033, 0, 2);  add(32'hFE00707F, 32'h00002033, 0, 3);
    add(32'hFE00707F, 32'h00003033, 0, 4);  add(32'hFE00707F, 32'h00004033, 0, 5);
    add(32'hFE00707F, 32'h00005033, 0, 6);  add(32'hFE00707F, 32'h40005033, 0, 7);
    add(32'hFE00707F, 32'h00006033, 0, 8);  add(32'hFE00707F, 32'h00007033, 0, 9);
    add(32'h0000707F, 32'h00000013, 0, 10); add(32'h0000707F, 32'h00002013, 0, 11);
    add(32'h0000707F, 32'h00003013, 0, 12); add(32'h0000707F, 32'h00004013, 0, 13);
    add(32'h0000707F, 32'h00006013, 0, 14); add(32'h0000707F, 32'h00007013, 0, 15);
    add(32'hFE00707F, 32'h00001013, 0, 16); add(32'hFE00707F, 32'h00005013, 0, 17);
    add(32'hFE00707F, 32'h40005013, 0, 18);
    add(32'h0000007F, 32'h0000006F, 1, 0);  add(32'h0000707F, 32'h00000067, 1, 1);
    add(32'h0000707F, 32'h00000063, 1, 2);  add(32'h0000707F, 32'h00001063, 1, 3);
    add(32'h0000707F, 32'h00004063, 1, 4);  add(32'h0000707F, 32'h00005063, 1, 5);
    add(32'h0000707F, 32'h00006063, 1, 6);  add(32'h0000707F, 32'h00007063, 1, 7);
    add(32'h0000007F, 32'h00000017, 1, 8);
    add(32'h0000707F, 32'h00000003, 2, 0);  add(32'h0000707F, 32'h00001003, 2, 1);
    add(32'h0000707F, 32'h00002003, 2, 2);  add(32'h0000707F, 32'h00004003, 2, 3);
    add(32'h0000707F, 32'h00005003, 2, 4);  add(32'h0000707F, 32'h00000023, 2, 5);
    add(32'h0000707F, 32'h00001023, 2, 6);  add(32'h0000707F, 32'h00002023, 2, 7);
    add(32'h0000007F, 32'h00000037, 2, 8);
    add(32'h0000707F, 32'h00001073, 3, 0);  add(32'h0000707F, 32'h00002073, 3, 1);
    add(32'h0000707F, 32'h00003073, 3, 2);  add(32'h0000707F, 32'h00005073, 3, 3);
    add(32'h0000707F, 32'h00006073, 3, 4);  add(32'h0000707F, 32'h00007073, 3, 5);
    add(32'hFFFFFFFF, 32'h00000073, 4, 0);  add(32'hFFFFFFFF, 32'h00100073, 4, 1);
    add(32'hFFFFFFFF, 32'h30200073, 4, 2);  add(32'hFFFFFFFF, 32'h10200073, 4, 3);
    add(32'hFFFFFFFF, 32'h00200073, 4, 4);  add(32'hFFFFFFFF, 32'h10500073, 4, 5);
    add(32'h0000707F, 32'h0000000F, 4, 6);  add(32'h0000707F, 32'h0000100F, 4, 7);
    add(32'h0000007F, 32'h0000007F, 5, 0);
  endtask

  function automatic logic [52:0] exp_ops(input logic [31:0] w, input logic e);
    logic [18:0] a;
    logic [8:0]  j, m;
    logic        c;
    logic [5:0]  s;
    logic [7:0]  x;
    logic        hit;
    a = '0; j = '0; m = '0; c = 1'b0; s = '0; x = '0; hit = 1'b0;
    if (e) begin
      foreach (t_mask[i]) begin
        if (!hit && ((w & t_mask[i]) == t_match[i])) begin
          hit = 1'b1;
          case (t_grp[i])
            0:       a[t_bit[i]] = 1'b1;
            1:       j[t_bit[i]] = 1'b1;
            2:       m[t_bit[i]] = 1'b1;
            3:       s[t_bit[i]] = 1'b1;
            4:       x[t_bit[i]] = 1'b1;
            default: c = 1'b1;
          endcase
        end
      end
    end
    return {e && !hit, a, j, m, c, s, x};
  endfunction

  function automatic logic [53:0] exp_flds(input logic [31:0] w);
    logic [4:0] f_rd, f_rs1, f_rs2;
    f_rd  = 5'((w >> 7) & 32'h1F);
    f_rs1 = 5'((w >> 15) & 32'h1F);
    f_rs2 = 5'((w >> 20) & 32'h1F);
    return {f_rd, f_rs1, f_rs2, 7'(w >> 25), 20'(w >> 12), 12'(w >> 20)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [31:0] w, input logic e);
    @(negedge clk);
    instruction_code = w;
    en = e;
    @(posedge clk);
    #1;
    check("ops", 64'(obs_ops), 64'(exp_ops(w, e)));
    check("fields", 64'(obs_flds), 64'(exp_flds(w)));
  endtask

  initial begin
    logic [31:0] w;
    int k;
    init_table();
    rst = 1'b1;
    en = 1'b0;
    instruction_code = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ops", 64'(obs_ops), 64'h0);
    check("reset_flds", 64'(obs_flds), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    apply(32'h00000000, 1'b1);
    check("zero_invalid", 64'(invalid_instruction), 64'h1);
    check("zero_ops", 64'(obs_ops), 64'h10000000000000);

    apply(32'h00000797, 1'b1);
    check("auipc_jmp", 64'(jmp_op), 64'h100);
    check("auipc_rd", 64'(rd), 64'd15);
    check("auipc_imm", 64'(imm_1231), 64'h0);
    apply(32'h1a5000ef, 1'b1);
    check("jal_jmp", 64'(jmp_op), 64'h001);
    check("jal_rd", 64'(rd), 64'd1);
    apply(32'h02c78793, 1'b1);
    check("addi_alu", 64'(alu_op), 64'h00400);
    check("addi_imm", 64'(imm_2032), 64'd44);
    apply(32'h07f56513, 1'b1);
    check("ori_alu", 64'(alu_op), 64'h04000);
    check("ori_rs1", 64'(rs1), 64'd10);
    apply(32'h305793f3, 1'b1);
    check("csrrw_csr", 64'(csr_op), 64'h01);
    check("csrrw_imm", 64'(imm_2032), 64'h305);
    apply(32'h30200073, 1'b1);
    check("mret_mech", 64'(mechie_op), 64'h04);
    apply(32'h00112623, 1'b1);
    check("sw_mem", 64'(mem_op), 64'h080);
    check("sw_rd", 64'(rd), 64'd12);
    apply(32'h04079263, 1'b1);
    check("bne_jmp", 64'(jmp_op), 64'h008);
    check("bne_rs1", 64'(rs1), 64'd15);
    apply(32'h8000007F, 1'b1);
    check("cust_op", 64'(cust_op), 64'h1);
    check("cust_valid", 64'(invalid_instruction), 64'h0);

    apply(32'h02c78793, 1'b0);
    check("dis_ops", 64'(obs_ops), 64'h0);
    check("dis_rd", 64'(rd), 64'd15);

    // Encodings one field away from a legal instruction.
    apply(32'h40001033, 1'b1);
    apply(32'h02000033, 1'b1);
    apply(32'h40001013, 1'b1);
    apply(32'h20005013, 1'b1);
    apply(32'h00002063, 1'b1);
    apply(32'h00001067, 1'b1);
    apply(32'h00003003, 1'b1);
    apply(32'h00003023, 1'b1);
    apply(32'h00004073, 1'b1);
    apply(32'h00300073, 1'b1);
    apply(32'h0000200F, 1'b1);
    apply(32'h10500073, 1'b1);
    apply(32'h00100073, 1'b1);

    // Asynchronous reset between edges.
    apply(32'h02c78793, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ops", 64'(obs_ops), 64'h0);
    check("async_rst_flds", 64'(obs_flds), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    apply(32'h00112623, 1'b1);
    check("post_rst_mem", 64'(mem_op), 64'h080);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          k = $urandom_range(0, t_mask.size() - 1);
          w = t_match[k] | ($urandom() & ~t_mask[k]);
        end
        1: begin
          w = $urandom();
          w[6:0] = opcs[$urandom_range(0, 10)];
        end
        default: w = $urandom();
      endcase
      apply(w, ($urandom_range(0, 7) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
